// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl: load/store sequencer for a single-port sync RAM, sub-word stores done as read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned requests answer with resp_err instead of touching the RAM.
module ram_rmw_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_type_b,
  input  logic              req_type_hb,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [2:0] {IDLE, RD, LDR, MRG, WR, ERR} state_t;
  state_t state, state_nxt;
  logic we_q, b_q, hb_q, misalign, accept, unused_addr;
  logic [1:0] lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, mrg_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] lo, input logic b, input logic hb);
    return lo == 2'd0 ? {hb ? old[31:16] : wd[31:16], b ? old[15:8] : wd[15:8], wd[7:0]} :
           lo == 2'd1 ? {hb ? old[31:24] : wd[23:16], b ? old[23:16] : wd[15:8], wd[7:0], old[7:0]} :
           lo == 2'd2 ? {b ? old[31:24] : wd[15:8], wd[7:0], old[15:0]} :
                        {wd[7:0], old[23:0]};
  endfunction

  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign accept = req_valid && state == IDLE;
`ifdef MISALIGN_TRAP_EN
  assign misalign = (!req_type_hb && req_addr[1:0] != 2'd0) ||
                    (req_type_hb && !req_type_b && req_addr[1:0] == 2'd3);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      b_q     <= 1'b0;
      hb_q    <= 1'b0;
      lo_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mrg_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        b_q     <= req_type_b;
        hb_q    <= req_type_hb;
        lo_q    <= req_addr[1:0];
        addr_q  <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
      end
      if (state == MRG) mrg_q <= merge(ram_rdata, wdata_q, lo_q, b_q, hb_q);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = misalign ? ERR : (req_we && !req_type_hb) ? WR : RD;
      RD:      state_nxt = we_q ? MRG : LDR;
      MRG:     state_nxt = WR;
      default: state_nxt = IDLE;
    endcase
    req_ready  = state == IDLE;
    ram_en     = state == RD || state == WR;
    ram_we     = state == WR;
    ram_addr   = ram_en ? addr_q : '0;
    // word stores skip the read, so any bytes below lo are written as zero
    ram_wdata  = state != WR ? '0 : hb_q ? mrg_q : merge('0, wdata_q, lo_q, 1'b0, 1'b0);
    resp_valid = state == LDR || state == WR || state == ERR;
    resp_rdata = state == LDR ? ram_rdata : '0;
`ifdef MISALIGN_TRAP_EN
    resp_err   = state == ERR;
`else
    resp_err   = 1'b0;
`endif
  end
endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// tb_ram_rmw_ctrl: randomized and directed stimulus against a byte-lane reference model and RAM image.
module tb_ram_rmw_ctrl;
  localparam int AW = 10;
  typedef struct packed {
    logic rdy, en, we, rv, err;
    logic [AW-1:0] a;
    logic [31:0] wd, rd;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_type_b = 1'b0, req_type_hb = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, ram_en, ram_we;
  logic [31:0] resp_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  int checks = 0, fails = 0;
  int cyc = 0, acc_cyc = 0, resp_cyc = 0, rd_cnt = 0, wr_cnt = 0, err_cnt = 0;
  logic [31:0] last_rd = '0;
  logic chk_en = 1'b0, fill = 1'b0, poke = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [31:0] poke_d = '0;
  logic [31:0] mem [1<<AW];
  logic [31:0] ref_mem [1<<AW];
  exp_t q[$];
  exp_t ce;

  always #5 clk = ~clk;

  ram_rmw_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_type_b(req_type_b), .req_type_hb(req_type_hb),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] seed(input int i);
    return 32'(i) * 32'h9E3779B9 + 32'h01234567;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill) for (int i = 0; i < (1 << AW); i++) mem[i] <= seed(i);
    else if (poke) mem[poke_a] <= poke_d;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // store lands byte k of wd on lane lo+k; lanes past 3 fall off the word
  function automatic logic [31:0] store_word(input logic [31:0] old, input logic [31:0] wd,
                                             input int n, input int lo);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < n; k++) if (lo + k < 4) r[8*(lo+k) +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      ce = q.size() != 0 ? q.pop_front() : idle_e();
      chk("req_ready", 32'(req_ready), 32'(ce.rdy));
      chk("ram_en", 32'(ram_en), 32'(ce.en));
      chk("ram_we", 32'(ram_we), 32'(ce.we));
      chk("resp_valid", 32'(resp_valid), 32'(ce.rv));
      chk("resp_err", 32'(resp_err), 32'(ce.err));
      chk("resp_rdata", resp_rdata, ce.rd);
      if (ce.en) chk("ram_addr", 32'(ram_addr), 32'(ce.a));
      if (ce.we) chk("ram_wdata", ram_wdata, ce.wd);
    end
    if (resp_valid) begin
      resp_cyc = cyc;
      last_rd = resp_rdata;
    end
    if (resp_err) err_cnt++;
    if (ram_en && !ram_we) rd_cnt++;
    if (ram_en && ram_we) wr_cnt++;
  end

  task automatic poke_word(input int a, input logic [31:0] d);
    poke = 1'b1;
    poke_a = AW'(a);
    poke_d = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    poke = 1'b0;
  endtask

  // kind: 0 word, 1 halfword, 2 byte; called in an IDLE cycle, returns in the next IDLE cycle
  task automatic issue(input logic we, input int kind, input logic [31:0] addr, input logic [31:0] wd);
    int n, lo, nb;
    logic [AW-1:0] wa;
    logic [31:0] old;
    logic mis;
    exp_t e;
    n = kind == 0 ? 4 : kind == 1 ? 2 : 1;
    lo = int'(addr[1:0]);
    wa = addr[AW+1:2];
    old = ref_mem[wa];
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (n == 4 && lo != 0) || (n == 2 && lo == 3);
`endif
    req_valid = 1'b1;
    req_we = we;
    req_type_b = kind == 2;
    req_type_hb = kind != 0;
    req_addr = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    acc_cyc = cyc;
    e = '0;
    if (mis) begin
      e.rv = 1'b1;
      e.err = 1'b1;
      q.push_back(e);
    end else if (we && n == 4) begin
      e.en = 1'b1; e.we = 1'b1; e.a = wa; e.rv = 1'b1;
      e.wd = store_word('0, wd, 4, lo);
      q.push_back(e);
      ref_mem[wa] = e.wd;
    end else begin
      e.en = 1'b1; e.a = wa;
      q.push_back(e);
      e = '0;
      if (!we) begin
        e.rv = 1'b1;
        e.rd = old;
        q.push_back(e);
      end else begin
        q.push_back(e);
        e.en = 1'b1; e.we = 1'b1; e.a = wa; e.rv = 1'b1;
        e.wd = store_word(old, wd, n, lo);
        q.push_back(e);
        ref_mem[wa] = e.wd;
      end
    end
    nb = q.size();
    for (int i = 0; i < nb; i++) begin
      req_valid = 1'($urandom);
      req_we = 1'($urandom);
      req_type_b = 1'($urandom);
      req_type_hb = 1'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int r0, w0, e0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed(i);
    fill = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset ram_en", 32'(ram_en), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset ram_addr", 32'(ram_addr), 32'd0);
    chk("reset ram_wdata", ram_wdata, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    poke_word(4, 32'hAABBCCDD);
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 2, 32'h11, 32'h55);
    chk("byte store latency", 32'(resp_cyc - acc_cyc), 32'd2);
    chk("byte store ram", mem[4], 32'hAABB55DD);
    chk("byte store model", ref_mem[4], 32'hAABB55DD);
    chk("byte store reads", 32'(rd_cnt - r0), 32'd1);

    poke_word(4, 32'hAABBCCDD);
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 1, 32'h12, 32'h1234);
    chk("half store ram", mem[4], 32'h1234CCDD);
    chk("half store reads", 32'(rd_cnt - r0), 32'd1);
    chk("half store writes", 32'(wr_cnt - w0), 32'd1);

    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 0, 32'h20, 32'hDEADBEEF);
    chk("word store latency", 32'(resp_cyc - acc_cyc), 32'd0);
    chk("word store ram", mem[8], 32'hDEADBEEF);
    chk("word store reads", 32'(rd_cnt - r0), 32'd0);
    issue(1'b0, 0, 32'h20, 32'h0);
    chk("load latency", 32'(resp_cyc - acc_cyc), 32'd1);
    chk("load data", last_rd, 32'hDEADBEEF);

    poke_word(4, 32'hAABBCCDD);
    issue(1'b1, 2, 32'h13, 32'h99);
    issue(1'b0, 0, 32'h10, 32'h0);
    chk("b2b load data", last_rd, 32'h99BBCCDD);

    poke_word(4, 32'hAABBCCDD);
    r0 = rd_cnt; w0 = wr_cnt; e0 = err_cnt;
    issue(1'b1, 1, 32'h13, 32'hBEEF);
`ifdef MISALIGN_TRAP_EN
    chk("misalign err pulses", 32'(err_cnt - e0), 32'd1);
    chk("misalign ram cycles", 32'(rd_cnt - r0 + wr_cnt - w0), 32'd0);
    chk("misalign ram kept", mem[4], 32'hAABBCCDD);
`else
    chk("misalign err pulses", 32'(err_cnt - e0), 32'd0);
    chk("misalign ram", mem[4], 32'hEFBBCCDD);
`endif

    poke_word(4, 32'hAABBCCDD);
    chk_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_type_b = 1'b1; req_type_hb = 1'b1;
    req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rd ram_en before reset", 32'(ram_en), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async reset ram_en", 32'(ram_en), 32'd0);
    chk("async reset ram_we", 32'(ram_we), 32'd0);
    chk("async reset resp_valid", 32'(resp_valid), 32'd0);
    chk("async reset req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset req_ready", 32'(req_ready), 32'd1);
    chk("abandoned rmw ram", mem[4], 32'hAABBCCDD);
    chk_en = 1'b1;

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      issue(1'($urandom), int'($urandom_range(0, 2)), {26'd0, 6'($urandom)}, $urandom);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("ram word %0d", i), mem[i], ref_mem[i]);
    chk("queue drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ram_rmw_ctrl.md
Name: ram_rmw_ctrl

Overview:
- Sequencer in front of the single-port synchronous data RAM.
- Accepts one load or store request at a time from the memory stage and issues the RAM read and write cycles.
- Sub-word stores are done as read-modify-write: read the word, merge the new bytes by type and lower address, write the word back.
- Sits between the pipeline memory stage and the RAM macro; loads return the raw word (sign/zero extension is done downstream).

Parameters:
ADDR_W, 10, word-address width of RAM; ram_addr = req_addr[ADDR_W+1:2]

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept; 1 only in IDLE
req_we  input  1  1 = store, 0 = load
req_type_b  input  1  byte access (asserted together with req_type_hb)
req_type_hb  input  1  halfword-or-byte access
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  load word; valid with resp_valid on loads, 0 otherwise
resp_err  output  1  misalignment flag (only with MISALIGN_TRAP_EN; else tied 0)
ram_en  output  1  RAM cycle enable
ram_we  output  1  RAM write enable, qualified by ram_en
ram_addr  output  ADDR_W  RAM word address
ram_wdata  output  32  RAM write word
ram_rdata  input  32  RAM read word, valid the cycle after a read enable

Behaviour:
- Request is accepted on a rising edge with req_valid && req_ready.
  - The edge registers we, type_b, type_hb, addr, wdata and lo = addr[1:0].
- RAM-side outputs and resp_* depend only on state and registered fields; there is no combinational path from req_* to ram_* or resp_*.
- Access types: word = b0,hb0; halfword = b0,hb1; byte = b1,hb1.
- States:
  - IDLE: req_ready=1; all RAM and response outputs 0.
    - Word store -> WR.
    - Any other accepted request -> RD.
  - RD: ram_en=1, ram_we=0, ram_addr = registered word address.
    - Load -> LDR; sub-word store -> MRG.
  - LDR: resp_valid=1, resp_rdata=ram_rdata -> IDLE.
  - MRG: capture merged word into a register -> WR. Merge of wdata into ram_rdata, by lo:
    - lo=0: byte0=wd[7:0]; byte1=b?old:wd[15:8]; bytes3:2=hb?old:wd[31:16].
    - lo=1: byte0=old; byte1=wd[7:0]; byte2=b?old:wd[15:8]; byte3=hb?old:wd[23:16].
    - lo=2: bytes1:0=old; byte2=wd[7:0]; byte3=b?old:wd[15:8].
    - lo=3: bytes2:0=old; byte3=wd[7:0].
  - WR: ram_en=1, ram_we=1, resp_valid=1 -> IDLE.
    - ram_wdata = merged register for sub-word stores.
    - ram_wdata = word-store data, merged with "old" taken as 0 for lo!=0.
- Latency, counting the accept edge as edge 0 (pulse is high in the cycle after the stated edge):
  - Word store: ram write and resp_valid in the cycle after edge 0.
  - Load: resp_valid in the cycle after edge 1.
  - Sub-word store: write and resp_valid in the cycle after edge 2.
  - req_ready returns 1 in the cycle after the resp_valid cycle.
- No backpressure on resp: resp_valid is a single-cycle pulse.
- Back-to-back requests: the next request is accepted in the first IDLE cycle, so there is no gap beyond the IDLE cycle.
- Reset (asynchronous, any state):
  - State -> IDLE; ram_en, ram_we, resp_valid, resp_err drop to 0 immediately; all registers cleared.
  - An in-flight RMW is abandoned and the RAM word stays unmodified unless the WR edge had already occurred.
- Reset values: req_ready=1 after reset release; every other output 0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Misaligned requests are: halfword with lo=3, or word with lo!=0.
  - Such a request goes IDLE -> ERR; ERR pulses resp_valid=1 and resp_err=1 for one cycle with ram_en=0, then -> IDLE.
  - No RAM access is made; resp_rdata=0.
- Not defined:
  - resp_err tied 0.
  - Misaligned requests execute using the merge rules above, truncating the upper bytes, e.g. halfword at lo=3 writes only byte3.

Test Plan:
- Word 4 (byte addr 0x10) = 0xAABBCCDD; byte store addr 0x11, wdata 0x55 -> RD, MRG, WR sequence; ram_wdata 0xAABB55DD; resp_valid in the cycle after edge 2.
- Same word; halfword store addr 0x12, wdata 0x1234 -> ram_wdata 0x1234CCDD; one RAM read and one RAM write only.
- Word store addr 0x20, wdata 0xDEADBEEF -> single WR cycle with ram_addr 8, ram_wdata 0xDEADBEEF, no read; then load 0x20 -> resp_rdata 0xDEADBEEF in the cycle after edge 1.
- Back-to-back: byte store addr 0x13, 0x99 to word 0xAABBCCDD, then load 0x10 -> load returns 0x99BBCCDD; req_ready low throughout the first request.
- rst_n pulsed low during MRG of a byte store -> outputs 0 asynchronously; RAM word still 0xAABBCCDD; req_ready=1 after release.
- Halfword store addr 0x13, wdata 0xBEEF:
  - With MISALIGN_TRAP_EN: resp_err=1 pulse, ram_en never asserted.
  - Without: ram_wdata 0xEFBBCCDD.
